// File: rtl/dsd_shift_pkg.sv
// Shared types and constants for the serial shift-register blocks
// (transmit PISO and the matching receive-side shift register).
package dsd_shift_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } piso_state_t;

  localparam logic DIR_MSB_FIRST = 1'b0;
  localparam logic DIR_LSB_FIRST = 1'b1;

endpackage

// File: rtl/piso_shift_reg.sv
// Parallel-in serial-out shift register with valid/ready load and per-word
// bit order; a receiver using the same dir reassembles the word unchanged.
//
// state | meaning
// IDLE  | no word held, sout=0, ready for a load
// SHIFT | word in sr, current bit on sout, consumed on en
module piso_shift_reg
  import dsd_shift_pkg::*;
#(
  parameter int MSB = 8
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic           en,
  input  logic           dir,
  input  logic [MSB-1:0] din,
  input  logic           load_valid,
  output logic           load_ready,
  output logic           sout,
  output logic           sout_valid,
  output logic           done
);

  localparam int CW = $clog2(MSB);
  localparam logic [CW-1:0] LAST = CW'(MSB - 1);

  piso_state_t    state_q, state_d;
  logic [MSB-1:0] sr_q, sr_d;
  logic           dir_q, dir_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           done_q, done_d;
  logic           last_bit;
  logic           load_fire;

  assign last_bit   = (state_q == SHIFT) && (cnt_q == LAST);
  // Ready on the final consuming edge too, so back-to-back words have no gap.
  assign load_ready = (state_q == IDLE) || (last_bit && en);
  assign load_fire  = load_valid && load_ready;

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    dir_d   = dir_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    if (state_q == SHIFT && en) begin
      if (last_bit) begin
        done_d  = 1'b1;
        state_d = IDLE;
      end else begin
        cnt_d = cnt_q + 1'b1;
        if (dir_q == DIR_LSB_FIRST) sr_d = {1'b0, sr_q[MSB-1:1]};
        else                        sr_d = {sr_q[MSB-2:0], 1'b0};
      end
    end
    if (load_fire) begin
      sr_d    = din;
      dir_d   = dir;
      cnt_d   = '0;
      state_d = SHIFT;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      sr_q    <= '0;
      dir_q   <= DIR_MSB_FIRST;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      dir_q   <= dir_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  assign sout_valid = (state_q == SHIFT);
  assign sout       = (state_q != SHIFT)       ? 1'b0 :
                      (dir_q == DIR_LSB_FIRST) ? sr_q[0] : sr_q[MSB-1];
  assign done       = done_q;

endmodule

// File: tb/tb_piso_shift_reg.sv
// Directed bench for piso_shift_reg: bit order, stalls, back-to-back words,
// mid-word reset, with a behavioural receiver reassembling the serial stream.
module tb_piso_shift_reg;
  import dsd_shift_pkg::*;

  logic       clk;
  logic       rstn;
  logic       en;
  logic       dir;
  logic [7:0] din;
  logic       load_valid;
  logic       load_ready;
  logic       sout;
  logic       sout_valid;
  logic       done;

  int checks = 0;
  int errors = 0;

  logic       rx_dir;
  logic [7:0] rx;

  piso_shift_reg #(.MSB(8)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .en         (en),
    .dir        (dir),
    .din        (din),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .sout       (sout),
    .sout_valid (sout_valid),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Receiving shift register hooked up as a downstream link would be.
  initial rx = 8'h00;
  always @(posedge clk) begin
    if (sout_valid && en) begin
      if (rx_dir == DIR_LSB_FIRST) rx <= {sout, rx[7:1]};
      else                         rx <= {rx[6:0], sout};
    end
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle_out(input string tag);
    chk({tag, "_sout"},  {7'b0, sout},       8'h00);
    chk({tag, "_valid"}, {7'b0, sout_valid}, 8'h00);
    chk({tag, "_done"},  {7'b0, done},       8'h00);
    chk({tag, "_ready"}, {7'b0, load_ready}, 8'h01);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] exp_w;
    int         k;

    rstn = 1'b0; en = 1'b0; dir = 1'b0; din = 8'h00; load_valid = 1'b0;
    rx_dir = DIR_MSB_FIRST;
    #1;
    chk_idle_out("reset");
    #12;
    rstn = 1'b1;
    tick();
    chk_idle_out("post_reset");

    // A5, MSB first, en high
    exp_w = 8'hA5;
    din = exp_w; dir = DIR_MSB_FIRST; load_valid = 1'b1; en = 1'b1; rx_dir = DIR_MSB_FIRST;
    tick();
    load_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("a5_valid", {7'b0, sout_valid}, 8'h01);
      chk("a5_bit",   {7'b0, sout},       {7'b0, exp_w[7-i]});
      chk("a5_done",  {7'b0, done},       8'h00);
      tick();
    end
    chk("a5_done_pulse", {7'b0, done},       8'h01);
    chk("a5_end_valid",  {7'b0, sout_valid}, 8'h00);
    chk("a5_end_sout",   {7'b0, sout},       8'h00);
    chk("a5_rx",         rx,                 8'hA5);
    tick();
    chk("a5_done_clear", {7'b0, done},       8'h00);

    // 01, LSB first; dir flipped mid-word must not matter
    exp_w = 8'h01;
    din = exp_w; dir = DIR_LSB_FIRST; load_valid = 1'b1; rx_dir = DIR_LSB_FIRST;
    tick();
    load_valid = 1'b0; dir = DIR_MSB_FIRST;
    for (int i = 0; i < 8; i++) begin
      chk("01_bit",   {7'b0, sout},       {7'b0, exp_w[i]});
      chk("01_valid", {7'b0, sout_valid}, 8'h01);
      tick();
    end
    chk("01_done", {7'b0, done}, 8'h01);
    chk("01_rx",   rx,           8'h01);
    tick();

    // C3 with a 3-cycle stall while bit 2 is on sout; stray load during stall
    exp_w = 8'hC3;
    din = exp_w; dir = DIR_MSB_FIRST; load_valid = 1'b1; rx_dir = DIR_MSB_FIRST;
    tick();
    load_valid = 1'b0;
    k = 0;
    for (int c = 0; c < 11; c++) begin
      chk("c3_valid", {7'b0, sout_valid}, 8'h01);
      chk("c3_bit",   {7'b0, sout},       {7'b0, exp_w[7-k]});
      chk("c3_done",  {7'b0, done},       8'h00);
      en = !(c >= 2 && c <= 4);
      if (c == 3) begin
        load_valid = 1'b1; din = 8'h5A;
        #1;
        chk("c3_stall_ready", {7'b0, load_ready}, 8'h00);
      end else begin
        load_valid = 1'b0;
      end
      if (en) k++;
      tick();
    end
    en = 1'b1;
    chk("c3_done_pulse", {7'b0, done},       8'h01);
    chk("c3_end_valid",  {7'b0, sout_valid}, 8'h00);
    chk("c3_rx",         rx,                 8'hC3);
    tick();

    // 12 then 34 back-to-back with load_valid held high
    din = 8'h12; dir = DIR_MSB_FIRST; load_valid = 1'b1;
    tick();
    din = 8'h34;
    for (int c = 0; c < 16; c++) begin
      exp_w = (c < 8) ? 8'h12 : 8'h34;
      chk("b2b_valid", {7'b0, sout_valid}, 8'h01);
      chk("b2b_bit",   {7'b0, sout},       {7'b0, exp_w[7-(c%8)]});
      chk("b2b_done",  {7'b0, done},       {7'b0, c == 8});
      chk("b2b_ready", {7'b0, load_ready}, {7'b0, (c % 8) == 7});
      if (c == 8) load_valid = 1'b0;
      tick();
    end
    chk("b2b_done_last", {7'b0, done},       8'h01);
    chk("b2b_end_valid", {7'b0, sout_valid}, 8'h00);
    chk("b2b_rx",        rx,                 8'h34);
    tick();

    // FF interrupted by reset after 4 bits, then 0F
    din = 8'hFF; load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("ff_mid_valid", {7'b0, sout_valid}, 8'h01);
    #2;
    rstn = 1'b0;
    #1;
    chk_idle_out("ff_async_rst");
    tick();
    chk("ff_rst_no_done", {7'b0, done}, 8'h00);
    #2;
    rstn = 1'b1;
    exp_w = 8'h0F;
    din = exp_w; load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("0f_bit",   {7'b0, sout},       {7'b0, exp_w[7-i]});
      chk("0f_valid", {7'b0, sout_valid}, 8'h01);
      tick();
    end
    chk("0f_done", {7'b0, done}, 8'h01);
    chk("0f_rx",   rx,           8'h0F);
    tick();
    chk_idle_out("final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/piso_shift_reg.md
# piso_shift_reg

Parallel-in, serial-out shift register with selectable bit order. It is the transmit-side counterpart of the serial-in bidirectional shift register: it accepts an `MSB`-bit word over a valid/ready load handshake and emits it one bit per enabled clock. The bit order is chosen so that a receiving shift register with the same `dir` value, fed from `sout`, reassembles the word unchanged. It sits between word-level logic and any single-bit serial link in the design.

## Interface
- `MSB`, default 8: word width in bits; legal range is 2 or more.
- `clk`  input  1  rising-edge clock.
- `rstn`  input  1  reset, asynchronous and active-low.
- `en`  input  1  shift enable. The bit currently on `sout` is consumed on a rising edge only when `en`=1.
- `dir`  input  1  bit order, sampled at load. 0 = MSB first; 1 = LSB first.
- `din`  input  `MSB`  parallel word to send.
- `load_valid`  input  1  `din` and `dir` are valid.
- `load_ready`  output  1  the block can accept a word this cycle.
- `sout`  output  1  serial data bit.
- `sout_valid`  output  1  `sout` holds a word bit.
- `done`  output  1  one-cycle pulse after the last bit of a word is consumed.

## Operation
- Two-state FSM.
  - IDLE: `sout_valid`=0.
  - SHIFT: `sout_valid`=1.
- Internal registers:
  - data register `sr[MSB-1:0]`;
  - latched direction `dir_q`;
  - bit counter `cnt`, `$clog2(MSB)` bits wide, counting consumed bits from 0 to `MSB`-1.
- `load_ready` = (state==IDLE) or (state==SHIFT and `cnt`==`MSB`-1 and `en`). This makes back-to-back words gapless.
- Load: a rising edge with `load_valid` and `load_ready` does the following:
  - `sr` <= `din`;
  - `dir_q` <= `dir`;
  - `cnt` <= 0;
  - state <= SHIFT.
- `sout` is combinational from `sr`:
  - `dir_q`=0: `sout` = `sr[MSB-1]`;
  - `dir_q`=1: `sout` = `sr[0]`;
  - in IDLE, `sout` = 0.
- Consume: a rising edge in SHIFT with `en`=1 and `cnt`<`MSB`-1 does the following:
  - `cnt`++;
  - `dir_q`=0: `sr` <= {`sr[MSB-2:0]`, 1'b0};
  - `dir_q`=1: `sr` <= {1'b0, `sr[MSB-1:1]`}.
- Last bit: a rising edge in SHIFT with `en`=1 and `cnt`==`MSB`-1 does the following:
  - `done` <= 1 for exactly one cycle;
  - if a load is presented, it takes effect on the same edge;
  - otherwise state <= IDLE.
- `en`=0 in SHIFT: all state holds and `sout` is stable. There is no limit on stall length.
- `load_valid` while not ready: ignored. `din` is not sampled.
- `dir` changes mid-word have no effect until the next load.

## Timing
- Reset values (asynchronous): state=IDLE, `sr`=0, `cnt`=0, `dir_q`=0. Outputs: `sout`=0, `sout_valid`=0, `done`=0, `load_ready`=1.
- Load latency: the first bit is on `sout`, with `sout_valid`=1, in the cycle after the load edge.
- Word duration: `MSB` enabled edges. With `en` tied high, an 8-bit word occupies 8 cycles.
- `done` rises on the edge that consumes the last bit and is high for that one following cycle.
- Back-to-back loads: `done`=1 and `sout_valid`=1 together, with `sout` already carrying bit 0 of the new word.
- Reset asserted mid-word: the word is dropped immediately, with no `done`. After `rstn` deasserts, the block is ready on the first edge.
- Receiver hookup: drive the receiver's `en` with `sout_valid & en`, its `d` with `sout`, and give it the same `dir`.

## Structure
- Shared package `dsd_shift_pkg` holds:
  - the state typedef `piso_state_t` {IDLE, SHIFT};
  - `DIR_MSB_FIRST`=1'b0 and `DIR_LSB_FIRST`=1'b1, also used by the receiver bench.
- Single module, no sub-modules. The counter and the FSM are small enough to stay inline.

## Test plan
- `MSB`=8, `en`=1, load 8'hA5 with `dir`=0 → `sout` = 1,0,1,0,0,1,0,1 on consecutive cycles. `done` pulses once. A looped-back receiver with `dir`=0 reads 8'hA5.
- Load 8'h01 with `dir`=1 → `sout` = 1,0,0,0,0,0,0,0. A receiver with `dir`=1 reads 8'h01.
- 8'hC3 with `dir`=0, `en` low for 3 cycles after bit 2 → `sout` holds 0 during the stall, then finishes. The total is 11 cycles; `done` pulses once.
- `load_valid` held high with words 8'h12 then 8'h34 → 16 contiguous `sout_valid` cycles. `done` pulses at cycles 8 and 16. A load attempt mid-word changes nothing.
- `rstn` pulled low after 4 bits of 8'hFF → outputs go to reset values asynchronously and no `done` is seen. After release, a new load of 8'h0F sends correctly.
